// File: rtl/uart_rx_deser_param.sv
// Serial-to-parallel deserializer for the UART receive path: one bit per
// oversampled period, LSB- or MSB-first. Optional macro PARITY_CALC_EN adds data_parity.
module uart_rx_deser_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          sampled_bit,
  input  logic                          deser_en,
  input  logic [PRESC_W-1:0]            edge_cnt,
  input  logic [PRESC_W-1:0]            Prescale,
  input  logic                          msb_first,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          data_valid,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx,
`ifdef PARITY_CALC_EN
  output logic                          busy,
  output logic                          data_parity
`else
  output logic                          busy
`endif
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  // data_valid is a one-cycle strobe with no back-pressure: P_DATA is stable
  // from the data_valid cycle until the next completion, and the consumer
  // must take it within that window.
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                  state_q, state_nxt;
  logic [IDX_W-1:0]        idx_q, idx_nxt;
  logic                    order_q;
  logic                    order_eff;
  logic [DATA_WIDTH-1:0]   shift_q, shift_nxt;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    dv_q;
  logic                    done;
  logic [PRESC_W-1:0]      presc_m1;
  logic                    presc_ok;
  logic                    stb;

  assign presc_m1 = Prescale - PRESC_W'(1);
  assign presc_ok = (Prescale >= PRESC_W'(2));
  assign stb      = deser_en && presc_ok && (edge_cnt == presc_m1);

  // The first bit of a word uses the live msb_first; later bits use the latch.
  assign order_eff = (idx_q == '0) ? msb_first : order_q;
  assign shift_nxt = order_eff ? {shift_q[DATA_WIDTH-2:0], sampled_bit}
                               : {sampled_bit, shift_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    done      = 1'b0;
    if (!deser_en) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
    end else if (stb) begin
      if (idx_q == LAST_IDX) begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
        done      = 1'b1;
      end else begin
        state_nxt = S_SHIFT;
        idx_nxt   = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      order_q  <= 1'b0;
      shift_q  <= '0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      dv_q    <= done;
      if (stb) shift_q <= shift_nxt;
      if (stb && (idx_q == '0)) order_q <= msb_first;
      // Load from shift_nxt so the word appears one cycle after its last strobe.
      if (done) p_data_q <= shift_nxt;
    end
  end

`ifdef PARITY_CALC_EN
  logic parity_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       parity_q <= 1'b0;
    else if (done) parity_q <= ^shift_nxt;
  end
  assign data_parity = parity_q;
`endif

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign bit_idx    = idx_q;
  assign busy       = (state_q == S_SHIFT);

endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
Parametrised serial-to-parallel converter for the UART receive path. It sits between the data sampler/edge counter and the RX FSM.
- Shifts in one sampled bit per oversampled bit period.
- Supports configurable word width and LSB-first or MSB-first bit order.
- Tracks its own bit position.
- Presents a completed word on P_DATA with a one-cycle data_valid strobe.

Parameters:
DATA_WIDTH, 8, number of data bits per word; legal range 5..9
PRESC_W, 6, width of Prescale and edge_cnt

Ports:
CLK  input  1  system clock; all logic on its rising edge
RST  input  1  asynchronous, active-high reset
sampled_bit  input  1  majority-voted bit from the data sampler
deser_en  input  1  high while the RX FSM is in the data-bit state
edge_cnt  input  PRESC_W  oversample edge counter within the current bit
Prescale  input  PRESC_W  oversampling ratio (8, 16 or 32 in normal use)
msb_first  input  1  0 = LSB received first (UART standard); 1 = MSB first
P_DATA  output  DATA_WIDTH  last completed parallel word
data_valid  output  1  one-cycle pulse when P_DATA is updated
bit_idx  output  clog2(DATA_WIDTH)  number of bits captured in the current word
busy  output  1  high from the first captured bit until word completion

Behaviour:
- Reset (RST=1, asynchronous):
  - P_DATA=0, data_valid=0, bit_idx=0, busy=0.
  - Shift register cleared; order latch = 0.
- Sample strobe:
  - stb = deser_en AND (edge_cnt == Prescale-1), with the subtraction done in PRESC_W bits.
  - Prescale < 2 is illegal: stb is forced low and no bit is ever captured.
- On stb with bit_idx=0:
  - msb_first is latched into the order latch.
  - That latch governs the whole word; msb_first changes mid-word are ignored.
- On each stb the shift register captures sampled_bit:
  - LSB-first: new bit enters at position DATA_WIDTH-1 and the register shifts right.
  - MSB-first: new bit enters at position 0 and the register shifts left.
  - After DATA_WIDTH strobes the word is in natural bit order.
- bit_idx:
  - Increments on each stb.
  - On the stb where bit_idx == DATA_WIDTH-1 it wraps to 0.
  - On the following cycle P_DATA is loaded with the completed word and data_valid=1 for exactly one cycle.
  - Latency: 1 CLK from the final strobe to data_valid.
- busy: set on the first stb of a word; cleared in the same cycle data_valid asserts.
- deser_en deasserted mid-word (abort):
  - bit_idx returns to 0 and busy to 0 on the next edge.
  - No data_valid is generated; P_DATA holds its previous value.
  - Partial shift contents are don't-care and are overwritten by the next word.
- P_DATA changes only on completion or reset; it holds otherwise (no continuous copy from the shift register).
- Back-to-back words (deser_en held high):
  - The next stb after completion starts a new word at bit_idx=0.
  - A data_valid cycle coinciding with a new stb is legal; both actions occur.
- FSM handshake: the RX FSM must sample P_DATA on data_valid or later, before the next completion.

Optional Feature:
Macro PARITY_CALC_EN.
- Defined:
  - Adds output data_parity (1 bit), registered together with P_DATA.
  - data_parity = XOR reduction of the completed word (even-parity bit).
  - Reset value 0; valid whenever data_valid is high and held until the next completion.
  - Lets the parity checker compare without its own XOR tree.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: RST pulsed mid-word after 4 bits -> P_DATA=0, data_valid=0, bit_idx=0, busy=0 immediately (asynchronous). The next word captures cleanly.
- LSB-first, DATA_WIDTH=8, Prescale=8:
  - Stimulus: serial 1,0,1,1,0,0,1,0 sampled at edge_cnt=7.
  - Response: P_DATA=8'h4D with a single data_valid pulse 1 CLK after the 8th strobe. data_parity=0 when PARITY_CALC_EN is defined.
- MSB-first, Prescale=16:
  - Stimulus: same bit stream; msb_first toggled to 0 after bit 3.
  - Response: P_DATA=8'hB2, since the order latched at bit 0 is kept.
- Abort: deser_en dropped after 5 strobes, then a full word 0xFF -> no data_valid for the aborted word; next P_DATA=8'hFF.
- Back-to-back: 0x55 then 0xAA with deser_en held high, Prescale=32 -> two data_valid pulses, P_DATA sequence 0x55 then 0xAA, bit_idx wraps 7->0.
- Width/illegal config:
  - DATA_WIDTH=5, bits 1,1,0,0,1 LSB-first -> P_DATA=5'h13.
  - Prescale=1 with deser_en high for 100 cycles -> no strobe and no data_valid.
